// File: rtl/sprite_draw_sched_pkg.sv
// Shared constants and types for the sprite draw scheduler.
// Grid bounds, erase job constants and scheduler state encoding.
package sprite_pkg;

    localparam int GRID_W = 32;
    localparam int GRID_H = 24;

    localparam logic [24:0] ERASE_SHAPE = 25'h1FFFFFF;
    localparam logic [2:0]  COL_BLACK   = 3'b000;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SCAN      = 3'd1;
    localparam logic [2:0] ST_E_ISSUE   = 3'd2;
    localparam logic [2:0] ST_E_WAIT    = 3'd3;
    localparam logic [2:0] ST_D_ISSUE   = 3'd4;
    localparam logic [2:0] ST_D_WAIT    = 3'd5;
    localparam logic [2:0] ST_FRAME_END = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_SCAN      = ST_SCAN,
        S_E_ISSUE   = ST_E_ISSUE,
        S_E_WAIT    = ST_E_WAIT,
        S_D_ISSUE   = ST_D_ISSUE,
        S_D_WAIT    = ST_D_WAIT,
        S_FRAME_END = ST_FRAME_END
    } sched_state_t;

    // True when a tile coordinate lies inside the visible grid.
    function automatic logic coord_ok(input logic [7:0] x, input logic [6:0] y);
        return (x < 8'(GRID_W)) && (y < 7'(GRID_H));
    endfunction

endpackage

// File: rtl/sprite_draw_sched_lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of a mask.
// o_any flags that at least one bit is set; o_idx is 0 otherwise.
module lowest_set_idx #(
    parameter int W  = 4,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  i_mask,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan from the top so the lowest set bit is the last to win.
    always_comb begin
        o_idx = '0;
        o_any = |i_mask;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_draw_sched.sv
// Frame scheduler feeding the 5x5 tile drawer.
// Serialises erase-old / draw-new jobs per pending sprite each frame tick.
module sprite_draw_sched
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      tick,
    input  logic [NUM_SPRITES-1:0]    req_valid,
    input  logic [8*NUM_SPRITES-1:0]  req_x,
    input  logic [7*NUM_SPRITES-1:0]  req_y,
    input  logic [25*NUM_SPRITES-1:0] req_shape,
    input  logic [3*NUM_SPRITES-1:0]  req_colour,
    output logic [NUM_SPRITES-1:0]    req_ack,
    input  logic                      draw_done,
    output logic                      go,
    output logic [7:0]                x_out,
    output logic [6:0]                y_out,
    output logic [24:0]               shape_out,
    output logic [2:0]                colour_out,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun,
    output logic                      timeout_err
);

    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    sched_state_t r_state;

    logic [NUM_SPRITES-1:0] r_pending;
    logic [IW-1:0]          r_sel;
    logic [CW-1:0]          r_wait_cnt;

    logic [7:0]  r_job_x;
    logic [6:0]  r_job_y;
    logic [24:0] r_job_shape;
    logic [2:0]  r_job_colour;

    logic [7:0] r_prev_x [NUM_SPRITES];
    logic [6:0] r_prev_y [NUM_SPRITES];
    logic       r_prev_valid [NUM_SPRITES];

    logic                   r_go;
    logic [7:0]             r_x_out;
    logic [6:0]             r_y_out;
    logic [24:0]            r_shape_out;
    logic [2:0]             r_colour_out;
    logic [NUM_SPRITES-1:0] r_ack;
    logic                   r_frame_done;
    logic                   r_overrun;
    logic                   r_timeout_err;

    logic [7:0]  w_x      [NUM_SPRITES];
    logic [6:0]  w_y      [NUM_SPRITES];
    logic [24:0] w_shape  [NUM_SPRITES];
    logic [2:0]  w_colour [NUM_SPRITES];

    logic [IW-1:0] w_sel;
    logic          w_any;
    logic          w_sel_ok;
    logic          w_wait_end;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_unpack
        assign w_x[g]      = req_x[8*g +: 8];
        assign w_y[g]      = req_y[7*g +: 7];
        assign w_shape[g]  = req_shape[25*g +: 25];
        assign w_colour[g] = req_colour[3*g +: 3];
    end

    lowest_set_idx #(
        .W  (NUM_SPRITES),
        .IW (IW)
    ) u_pick (
        .i_mask (r_pending),
        .o_idx  (w_sel),
        .o_any  (w_any)
    );

    assign w_sel_ok   = coord_ok(w_x[w_sel], w_y[w_sel]);
    assign w_wait_end = draw_done || (r_wait_cnt == CW'(TIMEOUT));

    // Scheduler FSM with registered drawer-side outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pending     <= '0;
            r_sel         <= '0;
            r_wait_cnt    <= '0;
            r_job_x       <= '0;
            r_job_y       <= '0;
            r_job_shape   <= '0;
            r_job_colour  <= '0;
            r_go          <= 1'b0;
            r_x_out       <= '0;
            r_y_out       <= '0;
            r_shape_out   <= '0;
            r_colour_out  <= '0;
            r_ack         <= '0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_prev_x[i]     <= '0;
                r_prev_y[i]     <= '0;
                r_prev_valid[i] <= 1'b0;
            end
        end else begin
            r_go         <= 1'b0;
            r_ack        <= '0;
            r_frame_done <= 1'b0;
            if (tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (tick) begin
                        r_pending <= req_valid;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!w_any) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_FRAME_END;
                    end else begin
                        r_sel        <= w_sel;
                        r_ack        <= {{(NUM_SPRITES-1){1'b0}}, 1'b1} << w_sel;
                        r_job_x      <= w_x[w_sel];
                        r_job_y      <= w_y[w_sel];
                        r_job_shape  <= w_shape[w_sel];
                        r_job_colour <= w_colour[w_sel];
                        if (!w_sel_ok) begin
                            r_pending[w_sel] <= 1'b0;
                        end else if (r_prev_valid[w_sel]) begin
                            r_go         <= 1'b1;
                            r_x_out      <= r_prev_x[w_sel];
                            r_y_out      <= r_prev_y[w_sel];
                            r_shape_out  <= ERASE_SHAPE;
                            r_colour_out <= COL_BLACK;
                            r_state      <= S_E_ISSUE;
                        end else begin
                            r_go         <= 1'b1;
                            r_x_out      <= w_x[w_sel];
                            r_y_out      <= w_y[w_sel];
                            r_shape_out  <= w_shape[w_sel];
                            r_colour_out <= w_colour[w_sel];
                            r_state      <= S_D_ISSUE;
                        end
                    end
                end
                S_E_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_E_WAIT;
                end
                S_E_WAIT: begin
                    if (w_wait_end) begin
                        if (!draw_done) begin
                            r_timeout_err <= 1'b1;
                        end
                        r_go         <= 1'b1;
                        r_x_out      <= r_job_x;
                        r_y_out      <= r_job_y;
                        r_shape_out  <= r_job_shape;
                        r_colour_out <= r_job_colour;
                        r_state      <= S_D_ISSUE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_D_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_D_WAIT;
                end
                S_D_WAIT: begin
                    if (w_wait_end) begin
                        if (!draw_done) begin
                            r_timeout_err <= 1'b1;
                        end
                        r_prev_x[r_sel]     <= r_job_x;
                        r_prev_y[r_sel]     <= r_job_y;
                        r_prev_valid[r_sel] <= 1'b1;
                        r_pending[r_sel]    <= 1'b0;
                        r_state             <= S_SCAN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_FRAME_END: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign go          = r_go;
    assign x_out       = r_x_out;
    assign y_out       = r_y_out;
    assign shape_out   = r_shape_out;
    assign colour_out  = r_colour_out;
    assign req_ack     = r_ack;
    assign frame_done  = r_frame_done;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state != S_IDLE);

endmodule
